cache_port_arbiter: RTL and testbench

// - Round-robin arbiter that shares the single CPU-side request port of cache_controller among NUM_REQ requesters.
// - Requesters are, for example, the I-fetch and D-load/store units of two cores.
// - Issues one transaction at a time and holds the grant until cache_controller signals completion.
// - Routes the response back to the granted requester; a watchdog flags a hung controller.
// - Sits between the core request buses and cache_controller (cpu_req_* / cpu_res_*).

---
 rtl/cache_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/cache_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_cache_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the CPU-side cache port arbiter.
package cache_pkg;

    localparam int WORD_SIZE_DEF = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: the search starts at ptr and wraps, and the
// first requesting bit wins. Kept standalone so a memory-side arbiter can reuse it.
module rr_priority_pick #(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    assign any = |req;

    // Walk the candidates in rotated order starting at ptr; the first hit wins.
    always_comb begin
        logic [IDX_W:0] cand;
        logic           found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the single cache_controller CPU port among
// NUM_REQ requesters. One transaction in flight at a time; completion is the
// rising edge of cpu_res_ready; a watchdog aborts a hung transaction.
//
// state     | meaning
// ARB_IDLE  | no transaction; pick and latch a new grant if any request
// ARB_ISSUE | one-cycle request pulse to the controller, req_ready to grantee
// ARB_WAIT  | waiting for the completion edge or watchdog expiry
module cache_port_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int WORD_SIZE      = WORD_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_rw,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_datain,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [WORD_SIZE-1:0]           resp_dataout,
    output logic                           cpu_req_enable,
    output logic                           cpu_req_rw,
    output logic [WORD_SIZE-1:0]           cpu_req_addr,
    output logic [WORD_SIZE-1:0]           cpu_req_datain,
    input  logic [WORD_SIZE-1:0]           cpu_res_dataout,
    input  logic                           cpu_res_ready,
    output logic                           busy,
    output logic                           timeout_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    // Down-counter loaded on entry to WAIT; terminal count 0 marks the last allowed WAIT cycle.
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   rw_q, rw_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   res_prev_q;
    logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
    logic [WORD_SIZE-1:0]   resp_data_q, resp_data_d;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   complete;

    rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // A level left high by the previous transaction must not complete a new one.
    assign complete = cpu_res_ready & ~res_prev_q;

    assign cpu_req_enable = (state_q == ARB_ISSUE);
    assign req_ready      = cpu_req_enable ? grant_q : '0;
    assign busy           = (state_q != ARB_IDLE);
    assign cpu_req_rw     = rw_q;
    assign cpu_req_addr   = addr_q;
    assign cpu_req_datain = wdata_q;
    assign resp_valid     = resp_valid_q;
    assign resp_dataout   = resp_data_q;
    assign timeout_err    = timeout_err_q;

    // Next-state, grant/payload latch, watchdog and response generation.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        rw_d          = rw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        resp_valid_d  = '0;
        resp_data_d   = resp_data_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    rw_d    = req_rw[pick_idx];
                    addr_d  = req_addr[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];
                    wdata_d = req_datain[int'(pick_idx)*WORD_SIZE +: WORD_SIZE];
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                wd_cnt_d = WD_LOAD;
                if (complete) begin
                    resp_valid_d = grant_q;
                    resp_data_d  = rw_q ? '0 : cpu_res_dataout;
                    state_d      = ARB_IDLE;
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (complete) begin
                    resp_valid_d = grant_q;
                    resp_data_d  = rw_q ? '0 : cpu_res_dataout;
                    state_d      = ARB_IDLE;
                end else if (WD_EN && (wd_cnt_q == '0)) begin
                    timeout_err_d = 1'b1;
                    resp_valid_d  = grant_q;
                    resp_data_d   = '0;
                    state_d       = ARB_IDLE;
                end else if (WD_EN) begin
                    wd_cnt_d = wd_cnt_q - WD_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            res_prev_q    <= 1'b0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            rw_q          <= rw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            res_prev_q    <= cpu_res_ready;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
            resp_valid_q  <= resp_valid_d;
            resp_data_q   <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: expected issues/responses are queued
// when stimulus is driven and popped by a negedge monitor.
module tb_cache_port_arbiter;

    localparam int NR = 2;
    localparam int WS = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_rw;
    logic [NR*WS-1:0]  req_addr;
    logic [NR*WS-1:0]  req_datain;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     resp_valid;
    logic [WS-1:0]     resp_dataout;
    logic              cpu_req_enable;
    logic              cpu_req_rw;
    logic [WS-1:0]     cpu_req_addr;
    logic [WS-1:0]     cpu_req_datain;
    logic [WS-1:0]     cpu_res_dataout;
    logic              cpu_res_ready;
    logic              busy;
    logic              timeout_err;

    cache_port_arbiter #(.NUM_REQ(NR), .WORD_SIZE(WS), .TIMEOUT_CYCLES(TO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_rw          (req_rw),
        .req_addr        (req_addr),
        .req_datain      (req_datain),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_dataout    (resp_dataout),
        .cpu_req_enable  (cpu_req_enable),
        .cpu_req_rw      (cpu_req_rw),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_datain  (cpu_req_datain),
        .cpu_res_dataout (cpu_res_dataout),
        .cpu_res_ready   (cpu_res_ready),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int g; logic rw; logic [31:0] addr; logic [31:0] wdata; } iss_t;
    typedef struct { int g; logic [31:0] data; } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_cyc   = 0;
    int resp_cyc = 0;
    int resp_cnt = 0;
    int m_ptr    = 0;
    bit outstanding = 1'b0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int g);
        onehot = 2'b01 << g;
    endfunction

    function automatic logic [127:0] outs_now();
        outs_now = {24'b0, req_ready, resp_valid, resp_dataout, cpu_req_enable, cpu_req_rw,
                    cpu_req_addr, cpu_req_datain, busy, timeout_err};
    endfunction

    function automatic int rr_model(input logic [1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            int c;
            c = (p + k) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_grant(input logic [1:0] v, output int g);
        g     = rr_model(v, m_ptr);
        m_ptr = (g + 1) % NR;
    endtask

    task automatic expect_txn(input int g, input logic rw, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rdata, input bit with_resp);
        iss_t e;
        rsp_t r;
        e.g = g; e.rw = rw; e.addr = a; e.wdata = d;
        iss_q.push_back(e);
        if (with_resp) begin
            r.g    = g;
            r.data = rw ? 32'h0 : rdata;
            rsp_q.push_back(r);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : monitor
        iss_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 1'b0;
            end else begin
                if (cpu_req_enable) begin
                    en_cyc = cyc;
                    check_eq("enable_while_busy", outstanding, 0);
                    outstanding = 1'b1;
                    check_eq("issue_busy", busy, 1);
                    if (iss_q.size() == 0) begin
                        check_eq("unexpected_enable", 1, 0);
                    end else begin
                        e = iss_q.pop_front();
                        check_eq("issue_ready", req_ready, onehot(e.g));
                        check_eq("issue_rw", cpu_req_rw, e.rw);
                        check_eq("issue_addr", cpu_req_addr, e.addr);
                        check_eq("issue_datain", cpu_req_datain, e.wdata);
                    end
                end else if (req_ready != '0) begin
                    check_eq("ready_without_enable", req_ready, 0);
                end
                if (resp_valid != '0) begin
                    resp_cyc    = cyc;
                    resp_cnt++;
                    outstanding = 1'b0;
                    if (rsp_q.size() == 0) begin
                        check_eq("unexpected_resp", resp_valid, 0);
                    end else begin
                        r = rsp_q.pop_front();
                        check_eq("resp_onehot", resp_valid, onehot(r.g));
                        check_eq("resp_data", resp_dataout, r.data);
                    end
                end
            end
        end
    end

    task automatic drive_req(input int i, input logic rw, input logic [31:0] a, input logic [31:0] d);
        req_rw[i]            = rw;
        req_addr[i*WS +: WS]   = a;
        req_datain[i*WS +: WS] = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_ready_any(output int idx, output int n);
        idx = -1;
        n   = 0;
        while (idx < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (req_ready[0]) idx = 0;
            else if (req_ready[1]) idx = 1;
        end
        if (idx < 0) check_eq("ready_wait_expired", 0, 1);
    endtask

    task automatic request(input int i, input logic rw, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        int idx, n;
        drive_req(i, rw, a, d);
        wait_ready_any(idx, n);
        check_eq("ready_idx", idx, i);
        lat = n - 1;
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_enable(output bit seen);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_req_enable && n < 60);
        seen = cpu_req_enable;
        if (!seen) check_eq("enable_wait_expired", 0, 1);
    endtask

    task automatic ctrl_respond(input int lat, input logic [31:0] d, input bit hold);
        bit seen;
        wait_enable(seen);
        if (seen) begin
            repeat (lat) @(posedge clk);
            #1;
            cpu_res_ready   = 1'b1;
            cpu_res_dataout = d;
            if (!hold) begin
                @(posedge clk);
                #1;
                cpu_res_ready   = 1'b0;
                cpu_res_dataout = 32'h0;
            end
        end
    endtask

    task automatic wait_resp_drain(input int limit);
        int n = 0;
        while (rsp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        check_eq("resp_drain", rsp_q.size(), 0);
        check_eq("issue_drain", iss_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : global_guard
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin : main
        int g, lat, idx, n, base;
        int cnt[2];
        rst_n           = 1'b0;
        req_valid       = '0;
        req_rw          = '0;
        req_addr        = '0;
        req_datain      = '0;
        cpu_res_ready   = 1'b0;
        cpu_res_dataout = '0;
        repeat (3) @(posedge clk);
        #1 check_eq("reset_outputs", outs_now(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read
        model_grant(2'b01, g);
        expect_txn(g, 1'b0, 32'h0000_0ABC, 32'h0, 32'hDEAD_BEEF, 1'b1);
        fork
            begin
                request(0, 1'b0, 32'h0000_0ABC, 32'h0, lat);
                check_eq("t1_req_to_enable", lat, 1);
            end
            ctrl_respond(3, 32'hDEAD_BEEF, 1'b0);
        join
        wait_resp_drain(40);
        check_eq("t1_resp_latency", resp_cyc - en_cyc, 4);

        // Write from requester 1
        model_grant(2'b10, g);
        expect_txn(g, 1'b1, 32'h0000_0DEF, 32'hCAFE_BABE, 32'h0, 1'b1);
        fork
            request(1, 1'b1, 32'h0000_0DEF, 32'hCAFE_BABE, lat);
            ctrl_respond(2, 32'h1234_5678, 1'b0);
        join
        wait_resp_drain(40);

        // Contention: both held across four transactions
        cnt[0] = 0;
        cnt[1] = 0;
        for (int k = 0; k < 4; k++) begin
            model_grant(2'b11, g);
            expect_txn(g, 1'b0, (g == 0 ? 32'h100 : 32'h200) + 32'(4 * cnt[g]), 32'h0,
                       32'h1000 + 32'(k), 1'b1);
            cnt[g]++;
        end
        drive_req(0, 1'b0, 32'h100, 32'h0);
        drive_req(1, 1'b0, 32'h200, 32'h0);
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    wait_ready_any(idx, n);
                    @(posedge clk);
                    #1;
                    if (k > 0) check_eq("t2_back_to_back", en_cyc - resp_cyc, 1);
                    if (idx >= 0) req_addr[idx*WS +: WS] = req_addr[idx*WS +: WS] + 32'd4;
                    if (k == 3) req_valid = '0;
                end
            end
            begin
                for (int k = 0; k < 4; k++) ctrl_respond(2, 32'h1000 + 32'(k), 1'b0);
            end
        join
        wait_resp_drain(40);

        // Stale ready: level left high must not complete the next transaction
        model_grant(2'b01, g);
        expect_txn(g, 1'b0, 32'h300, 32'h0, 32'hAAAA_0001, 1'b1);
        fork
            request(0, 1'b0, 32'h300, 32'h0, lat);
            ctrl_respond(2, 32'hAAAA_0001, 1'b1);
        join
        wait_resp_drain(40);
        model_grant(2'b10, g);
        expect_txn(g, 1'b0, 32'h400, 32'h0, 32'hBBBB_0002, 1'b1);
        base = resp_cnt;
        fork
            request(1, 1'b0, 32'h400, 32'h0, lat);
            begin
                bit seen;
                wait_enable(seen);
                repeat (5) @(posedge clk);
                check_eq("t4_stale_no_complete", resp_cnt - base, 0);
                #1 cpu_res_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                cpu_res_ready   = 1'b1;
                cpu_res_dataout = 32'hBBBB_0002;
                @(posedge clk);
                #1 cpu_res_ready = 1'b0;
            end
        join
        wait_resp_drain(40);

        // Completion on the watchdog's last WAIT cycle: completion wins
        model_grant(2'b01, g);
        expect_txn(g, 1'b0, 32'h500, 32'h0, 32'h0C0F_FEE0, 1'b1);
        fork
            request(0, 1'b0, 32'h500, 32'h0, lat);
            ctrl_respond(TO, 32'h0C0F_FEE0, 1'b0);
        join
        wait_resp_drain(40);
        check_eq("t5_collide_latency", resp_cyc - en_cyc, TO + 1);
        check_eq("t5_collide_no_err", timeout_err, 0);

        // Timeout: controller never answers
        model_grant(2'b10, g);
        expect_txn(g, 1'b0, 32'h510, 32'h0, 32'h0, 1'b1);
        request(1, 1'b0, 32'h510, 32'h0, lat);
        check_eq("t5_err_before", timeout_err, 0);
        wait_resp_drain(40);
        check_eq("t5_timeout_latency", resp_cyc - en_cyc, TO + 1);
        check_eq("t5_timeout_err", timeout_err, 1);
        model_grant(2'b01, g);
        expect_txn(g, 1'b0, 32'h520, 32'h0, 32'h5555_AAAA, 1'b1);
        fork
            request(0, 1'b0, 32'h520, 32'h0, lat);
            ctrl_respond(3, 32'h5555_AAAA, 1'b0);
        join
        wait_resp_drain(40);
        check_eq("t5_err_sticky", timeout_err, 1);

        // Reset during WAIT
        model_grant(2'b01, g);
        expect_txn(g, 1'b0, 32'h600, 32'h0, 32'h0, 1'b0);
        request(0, 1'b0, 32'h600, 32'h0, lat);
        repeat (2) @(posedge clk);
        check_eq("t6_busy_before", busy, 1);
        check_eq("t6_err_before", timeout_err, 1);
        #2 rst_n = 1'b0;
        #1 check_eq("t6_async_clear", outs_now(), 0);
        m_ptr = 0;
        base  = resp_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check_eq("t6_no_resp", resp_cnt - base, 0);
        model_grant(2'b11, g);
        expect_txn(g, 1'b0, (g == 0) ? 32'h600 : 32'h700, 32'h0, 32'h6666_7777, 1'b1);
        drive_req(0, 1'b0, 32'h600, 32'h0);
        drive_req(1, 1'b0, 32'h700, 32'h0);
        fork
            begin
                wait_ready_any(idx, n);
                check_eq("t6_ptr_reset_grant", idx, g);
                @(posedge clk);
                #1 req_valid = '0;
            end
            ctrl_respond(2, 32'h6666_7777, 1'b0);
        join
        wait_resp_drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
